// File: rtl/filter2d_linebuf.sv
// Streaming 3x3 FIR over an IMG_W x IMG_H 8-bit frame held in a single-port SRAM.
// Each pixel is read once; two line buffers and a 3x3 window feed a 9-tap MAC.
module filter2d_linebuf #(
   parameter int unsigned IMG_W    = 256,
   parameter int unsigned IMG_H    = 256,
   parameter int unsigned ADDR_W   = 17,
   parameter int unsigned OUT_BASE = IMG_W * IMG_H,
   parameter int unsigned SHIFT    = 7
) (
   input  logic              clk_i,
   input  logic              n_reset_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              finish_o,
   output logic              cs_o,
   output logic              we_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [7:0]        din_o,
   input  logic [7:0]        dout_i,
   input  logic              h_write_i,
   input  logic [3:0]        h_idx_i,
   input  logic [7:0]        h_data_i
);

   localparam int unsigned NumPix  = IMG_W * IMG_H;
   localparam int unsigned NumSlot = NumPix + IMG_W + 2;
   localparam int unsigned KW      = $clog2(NumSlot);
   localparam int unsigned CW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW      = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [KW-1:0]         KNumPix  = KW'(NumPix);
   localparam logic [KW-1:0]         KFirstWr = KW'(IMG_W + 2);
   localparam logic [KW-1:0]         KLast    = KW'(NumSlot - 1);
   localparam logic [CW-1:0]         ColLast  = CW'(IMG_W - 1);
   localparam logic [RW-1:0]         RowLast  = RW'(IMG_H - 1);
   localparam logic [ADDR_W-1:0]     OutBaseA = ADDR_W'(OUT_BASE);
   localparam logic signed [20:0]    Rnd      = 21'sd1 <<< (SHIFT - 1);
   localparam logic signed [7:0]     DefTaps [9] = '{8'sd8, 8'sd16, 8'sd8,
                                                     8'sd16, 8'sd32, 8'sd16,
                                                     8'sd8, 8'sd16, 8'sd8};

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e              state_q, state_d;
   logic                phase_q, phase_d;
   logic [KW-1:0]       k_q, k_d;
   logic [CW-1:0]       col_q, col_d;
   logic [CW-1:0]       out_col_q, out_col_d;
   logic [RW-1:0]       out_row_q, out_row_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic signed [7:0]   taps_q [9];
   logic signed [7:0]   taps_d [9];
   logic [7:0]          win_q [3][3];
   logic [7:0]          win_d [3][3];
   logic [7:0]          lb0_q [IMG_W];
   logic [7:0]          lb1_q [IMG_W];

   logic                lb_we;
   logic [7:0]          pix_in;
   logic [7:0]          lb0_rd;
   logic [7:0]          lb1_rd;
   logic                wr_slot;
   logic [7:0]          pix_out;

   assign lb0_rd  = lb0_q[col_q];
   assign lb1_rd  = lb1_q[col_q];
   assign pix_in  = (k_q < KNumPix) ? dout_i : 8'h00;
   assign wr_slot = (k_q >= KFirstWr);

   always_ff @(posedge clk_i) begin
      if (!n_reset_i) begin
         state_q   <= StIdle;
         phase_q   <= 1'b0;
         k_q       <= '0;
         col_q     <= '0;
         out_col_q <= '0;
         out_row_q <= '0;
         waddr_q   <= OutBaseA;
         taps_q    <= DefTaps;
         win_q     <= '{default: '0};
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         k_q       <= k_d;
         col_q     <= col_d;
         out_col_q <= out_col_d;
         out_row_q <= out_row_d;
         waddr_q   <= waddr_d;
         taps_q    <= taps_d;
         win_q     <= win_d;
      end
   end

   // Line buffers need no reset: out-of-frame taps are masked at the MAC.
   always_ff @(posedge clk_i) begin
      if (lb_we) begin
         lb0_q[col_q] <= pix_in;
         lb1_q[col_q] <= lb0_rd;
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      k_d       = k_q;
      col_d     = col_q;
      out_col_d = out_col_q;
      out_row_d = out_row_q;
      waddr_d   = waddr_q;
      taps_d    = taps_q;
      win_d     = win_q;
      lb_we     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d   = StRun;
               phase_d   = 1'b0;
               k_d       = '0;
               col_d     = '0;
               out_col_d = '0;
               out_row_d = '0;
               waddr_d   = OutBaseA;
            end
         end
         StRun: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               lb_we = 1'b1;
               for (int r = 0; r < 3; r++) begin
                  win_d[r][0] = win_q[r][1];
                  win_d[r][1] = win_q[r][2];
               end
               win_d[0][2] = lb1_rd;
               win_d[1][2] = lb0_rd;
               win_d[2][2] = pix_in;
               col_d = (col_q == ColLast) ? '0 : col_q + 1'b1;
               if (wr_slot) begin
                  waddr_d = waddr_q + 1'b1;
                  if (out_col_q == ColLast) begin
                     out_col_d = '0;
                     out_row_d = (out_row_q == RowLast) ? '0 : out_row_q + 1'b1;
                  end else begin
                     out_col_d = out_col_q + 1'b1;
                  end
               end
               if (k_q == KLast) begin
                  state_d = StDone;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Kernel is frozen while a frame runs so every output uses the same taps.
      if (state_q != StRun && h_write_i) begin
         for (int i = 0; i < 9; i++) begin
            if (h_idx_i == 4'(i)) taps_d[i] = $signed(h_data_i);
         end
      end
   end

   logic [2:0]          row_ok;
   logic [2:0]          col_ok;
   logic [7:0]          tap_pix [9];
   logic signed [16:0]  px_ext;
   logic signed [16:0]  tp_ext;
   logic signed [16:0]  prod;
   logic signed [20:0]  acc;
   logic signed [20:0]  acc_rnd;
   logic signed [20:0]  res;

   // Window is sampled before this slot's shift, so its centre is pixel k-IMG_W-2.
   always_comb begin
      row_ok  = {out_row_q != RowLast, 1'b1, out_row_q != '0};
      col_ok  = {out_col_q != ColLast, 1'b1, out_col_q != '0};
      px_ext  = '0;
      tp_ext  = '0;
      prod    = '0;
      acc     = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            tap_pix[r*3+c] = (row_ok[r] && col_ok[c]) ? win_q[r][c] : 8'h00;
         end
      end
      for (int i = 0; i < 9; i++) begin
         px_ext = {9'b0, tap_pix[i]};
         tp_ext = {{9{taps_q[i][7]}}, taps_q[i]};
         prod   = px_ext * tp_ext;
         acc    = acc + {{4{prod[16]}}, prod};
      end
      acc_rnd = acc + Rnd;
      res     = acc_rnd >>> SHIFT;
      if (res[20]) begin
         pix_out = 8'h00;
      end else if (|res[19:8]) begin
         pix_out = 8'hff;
      end else begin
         pix_out = res[7:0];
      end
   end

   always_comb begin
      cs_o     = 1'b0;
      we_o     = 1'b0;
      addr_o   = '0;
      din_o    = '0;
      busy_o   = (state_q == StRun);
      finish_o = (state_q == StDone);
      if (state_q == StRun) begin
         if (!phase_q) begin
            if (k_q < KNumPix) begin
               cs_o   = 1'b1;
               addr_o = ADDR_W'(k_q);
            end
         end else if (wr_slot) begin
            cs_o   = 1'b1;
            we_o   = 1'b1;
            addr_o = waddr_q;
            din_o  = pix_out;
         end
      end
   end

endmodule
